// File: rtl/memory_access.sv
// Pipeline memory stage: issues loads/stores over a req/gnt/rvalid data-memory port,
// formats load data and hands instruction plus writeback data to the writeback stage.
module memory_access (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr_i,
  input  logic [31:0] alu_result_i,
  input  logic [31:0] rs2_i,
  output logic        stall_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_gnt_i,
  input  logic        dmem_rvalid_i,
  input  logic [31:0] dmem_rdata_i,
  output logic [31:0] instr_o,
  output logic [31:0] rd_data_o,
  output logic [4:0]  sel_rd_o,
  output logic        err_o
);
  // Handshake: a request is presented in REQ and held stable until dmem_gnt_i is
  // seen high on a rising edge; load data is taken on the first dmem_rvalid_i in WAIT.
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
  state_t state;

  logic [31:0] h_instr;
  logic [31:0] h_addr;
  logic [31:0] h_rs2;

  logic [2:0] in_f3;
  logic       in_load;
  logic       in_store;
  logic       in_mem;
  logic       in_legal;
  logic       in_misaligned;
  logic       in_fault;

  always_comb begin
    in_f3         = instr_i[14:12];
    in_load       = (instr_i[6:0] == OP_LOAD);
    in_store      = (instr_i[6:0] == OP_STORE);
    in_mem        = in_load | in_store;
    in_legal      = 1'b0;
    case (in_f3)
      3'b000, 3'b001, 3'b010: in_legal = 1'b1;
      3'b100, 3'b101:         in_legal = in_load;
      default:                in_legal = 1'b0;
    endcase
    in_misaligned = ((in_f3[1:0] == 2'b01) && alu_result_i[0]) ||
                    ((in_f3[1:0] == 2'b10) && (alu_result_i[1:0] != 2'b00));
    in_fault      = in_mem & (~in_legal | in_misaligned);
  end

  logic       h_store;
  logic [2:0] h_f3;
  assign h_store = (h_instr[6:0] == OP_STORE);
  assign h_f3    = h_instr[14:12];

  logic [3:0]  st_be;
  logic [31:0] st_wdata;

  always_comb begin
    st_be    = 4'b1111;
    st_wdata = h_rs2;
    if (h_store) begin
      case (h_f3[1:0])
        2'b00: begin
          st_be    = 4'b0001 << h_addr[1:0];
          st_wdata = {4{h_rs2[7:0]}};
        end
        2'b01: begin
          st_be    = h_addr[1] ? 4'b1100 : 4'b0011;
          st_wdata = {2{h_rs2[15:0]}};
        end
        default: ;
      endcase
    end
  end

  // Memory port is driven only from state and holding registers, zero outside REQ.
  logic in_req;
  assign in_req       = (state == REQ);
  assign dmem_req_o   = in_req;
  assign dmem_we_o    = in_req & h_store;
  assign dmem_addr_o  = in_req ? {h_addr[31:2], 2'b00} : 32'd0;
  assign dmem_be_o    = in_req ? st_be : 4'd0;
  assign dmem_wdata_o = in_req ? st_wdata : 32'd0;

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  always_comb begin
    case (h_addr[1:0])
      2'b00:   ld_byte = dmem_rdata_i[7:0];
      2'b01:   ld_byte = dmem_rdata_i[15:8];
      2'b10:   ld_byte = dmem_rdata_i[23:16];
      default: ld_byte = dmem_rdata_i[31:24];
    endcase
    ld_half = h_addr[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
    case (h_f3)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_data = {24'd0, ld_byte};
      3'b101:  ld_data = {16'd0, ld_half};
      default: ld_data = dmem_rdata_i;
    endcase
  end

  logic stall;
  always_comb begin
    case (state)
      IDLE:    stall = in_mem & ~in_fault;
      REQ:     stall = ~(dmem_gnt_i & h_store);
      WAIT:    stall = ~dmem_rvalid_i;
      default: stall = 1'b0;
    endcase
  end
  assign stall_o = stall & rst_n;

  assign sel_rd_o = ((instr_o[6:0] == OP_LOAD) || (instr_o[6:0] == OP_RTYPE)) ?
                    instr_o[11:7] : 5'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      h_instr   <= 32'd0;
      h_addr    <= 32'd0;
      h_rs2     <= 32'd0;
      instr_o   <= 32'd0;
      rd_data_o <= 32'd0;
      err_o     <= 1'b0;
    end else begin
      err_o <= 1'b0;
      case (state)
        IDLE: begin
          if (in_fault) begin
            instr_o   <= 32'd0;
            rd_data_o <= 32'd0;
            err_o     <= 1'b1;
          end else if (in_mem) begin
            h_instr   <= instr_i;
            h_addr    <= alu_result_i;
            h_rs2     <= rs2_i;
            instr_o   <= 32'd0;
            rd_data_o <= 32'd0;
            state     <= REQ;
          end else begin
            instr_o   <= instr_i;
            rd_data_o <= alu_result_i;
          end
        end
        REQ: begin
          if (dmem_gnt_i && h_store) begin
            instr_o   <= h_instr;
            rd_data_o <= 32'd0;
            state     <= IDLE;
          end else begin
            instr_o <= 32'd0;
            if (dmem_gnt_i) state <= WAIT;
          end
        end
        WAIT: begin
          if (dmem_rvalid_i) begin
            instr_o   <= h_instr;
            rd_data_o <= ld_data;
            state     <= IDLE;
          end else begin
            instr_o <= 32'd0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_memory_access.sv
// Bench for memory_access: directed vector table, reset-abort sequences and
// randomized operations checked against a byte-level reference model.
module tb_memory_access;
  logic        clk;
  logic        rst_n;
  logic [31:0] instr_i, alu_result_i, rs2_i;
  logic        stall_o, dmem_req_o, dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_wdata_o;
  logic        dmem_gnt_i, dmem_rvalid_i;
  logic [31:0] dmem_rdata_i;
  logic [31:0] instr_o, rd_data_o;
  logic [4:0]  sel_rd_o;
  logic        err_o;

  int n_checks = 0;
  int n_pass   = 0;

  memory_access dut (
    .clk(clk), .rst_n(rst_n), .instr_i(instr_i), .alu_result_i(alu_result_i),
    .rs2_i(rs2_i), .stall_o(stall_o), .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
    .dmem_addr_o(dmem_addr_o), .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o),
    .dmem_gnt_i(dmem_gnt_i), .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
    .instr_o(instr_o), .rd_data_o(rd_data_o), .sel_rd_o(sel_rd_o), .err_o(err_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    int          stall;
    bit          req;
    bit          we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] iout;
    logic [31:0] rd;
    logic [4:0]  sel;
    bit          err;
  } exp_t;

  typedef struct {
    int          stall;
    bit          req, we, unstable, leak, timeout, err, err_after;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata, iout, rd;
    logic [4:0]  sel;
  } obs_t;

  typedef struct {
    string       name;
    logic [31:0] ins, alu, rs2, rdata;
    int          gd, rvd;
    exp_t        e;
  } vec_t;

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endfunction

  // Reference model: byte-lane arithmetic over access size and offset.
  function automatic exp_t model(input logic [31:0] ins, alu, rs2, rdata, input int gd, rvd);
    exp_t e;
    int size, off, bmask;
    logic [2:0] f3;
    logic [31:0] mask, val;
    bit ld, st, legal;
    e = '{default: 0};
    f3 = ins[14:12];
    ld = (ins[6:0] == 7'h03);
    st = (ins[6:0] == 7'h23);
    size = 1 << f3[1:0];
    off = int'(alu % 4);
    legal = ld ? (f3 != 3'd3 && f3 < 3'd6) : (f3 < 3'd3);
    if (!ld && !st) begin
      e.iout = ins;
      e.rd = alu;
      e.sel = (ins[6:0] == 7'h33) ? ins[11:7] : 5'd0;
    end else if (!legal || (alu % size) != 0) begin
      e.err = 1;
    end else begin
      e.req = 1;
      e.we = st;
      e.addr = alu - off;
      e.iout = ins;
      e.sel = ld ? ins[11:7] : 5'd0;
      if (st) begin
        bmask = ((1 << size) - 1) << off;
        e.be = bmask[3:0];
        for (int l = 0; l < 4; l++) e.wdata[8*l +: 8] = rs2[8*(l % size) +: 8];
        e.rd = 0;
        e.stall = gd + 1;
      end else begin
        e.be = 4'hF;
        mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*size)) - 1);
        val = (rdata >> (8*off)) & mask;
        if (!f3[2] && size < 4 && val[8*size-1]) val = val | ~mask;
        e.rd = val;
        e.stall = gd + rvd + 2;
      end
    end
    return e;
  endfunction

  // Driver + memory responder: presents one instruction, grants after gd REQ
  // cycles, returns rdata after rvd WAIT cycles, injects stray rvalid outside WAIT.
  task automatic run_op(input logic [31:0] ins, alu, rs2, rdata, input int gd, rvd, output obs_t o);
    int  cyc = 0, gcnt = 0, wcnt = 0;
    bit  done = 0, in_wait = 0, gnt_ld, st;
    o = '{default: 0};
    @(negedge clk);
    instr_i = ins; alu_result_i = alu; rs2_i = rs2;
    while (!done && cyc < 64) begin
      dmem_gnt_i = 0; dmem_rvalid_i = 0; dmem_rdata_i = $urandom; gnt_ld = 0;
      if (dmem_req_o) begin
        if (!o.req) begin
          o.req = 1; o.we = dmem_we_o; o.addr = dmem_addr_o;
          o.be = dmem_be_o; o.wdata = dmem_wdata_o;
        end else if (o.we != dmem_we_o || o.addr != dmem_addr_o ||
                     o.be != dmem_be_o || o.wdata != dmem_wdata_o) begin
          o.unstable = 1;
        end
        dmem_rvalid_i = 1'($urandom_range(0, 1));
        if (gcnt == gd) begin
          dmem_gnt_i = 1;
          gnt_ld = !dmem_we_o;
        end else gcnt++;
      end else if (in_wait) begin
        if (wcnt == rvd) begin
          dmem_rvalid_i = 1; dmem_rdata_i = rdata;
        end else wcnt++;
      end else begin
        dmem_rvalid_i = 1'($urandom_range(0, 1));
      end
      #1 st = stall_o;
      @(posedge clk); #1;
      if (gnt_ld) in_wait = 1;
      if (st) begin
        o.stall++;
        if (instr_o != 0 || err_o) o.leak = 1;
      end else begin
        done = 1;
        o.iout = instr_o; o.rd = rd_data_o; o.sel = sel_rd_o; o.err = err_o;
      end
      cyc++;
      if (!done) @(negedge clk);
    end
    if (!done) o.timeout = 1;
    @(negedge clk);
    instr_i = 0; alu_result_i = 0; rs2_i = 0; dmem_gnt_i = 0; dmem_rvalid_i = 0;
    @(posedge clk); #1;
    o.err_after = err_o;
  endtask

  // scoreboard comparison of one operation
  task automatic compare(input string nm, input obs_t o, input exp_t e);
    check({nm, ".timeout"}, 32'(o.timeout), 0);
    check({nm, ".stall"}, o.stall, e.stall);
    check({nm, ".req"}, 32'(o.req), 32'(e.req));
    if (e.req) begin
      check({nm, ".we"}, 32'(o.we), 32'(e.we));
      check({nm, ".addr"}, o.addr, e.addr);
      check({nm, ".be"}, 32'(o.be), 32'(e.be));
      if (e.we) check({nm, ".wdata"}, o.wdata, e.wdata);
      check({nm, ".req_stable"}, 32'(o.unstable), 0);
    end
    check({nm, ".instr_o"}, o.iout, e.iout);
    check({nm, ".rd_data"}, o.rd, e.rd);
    check({nm, ".sel_rd"}, 32'(o.sel), 32'(e.sel));
    check({nm, ".err"}, 32'(o.err), 32'(e.err));
    check({nm, ".stall_edge_zero"}, 32'(o.leak), 0);
    check({nm, ".err_one_cycle"}, 32'(o.err_after), 0);
  endtask

  task automatic check_all_zero(input string nm);
    check({nm, ".req"}, 32'(dmem_req_o), 0);
    check({nm, ".we"}, 32'(dmem_we_o), 0);
    check({nm, ".addr"}, dmem_addr_o, 0);
    check({nm, ".be"}, 32'(dmem_be_o), 0);
    check({nm, ".wdata"}, dmem_wdata_o, 0);
    check({nm, ".stall"}, 32'(stall_o), 0);
    check({nm, ".instr_o"}, instr_o, 0);
    check({nm, ".rd_data"}, rd_data_o, 0);
    check({nm, ".sel_rd"}, 32'(sel_rd_o), 0);
    check({nm, ".err"}, 32'(err_o), 0);
  endtask

  vec_t vecs[$];
  obs_t obs;
  exp_t e;
  logic [31:0] r_ins, r_alu, r_rs2, r_rdata;
  int r_gd, r_rvd, kind;

  initial begin
    vecs.push_back('{"rtype", 32'h002081B3, 32'h55, 32'h0, 32'h0, 0, 0,
                     '{0, 0, 0, 32'h0, 4'h0, 32'h0, 32'h002081B3, 32'h55, 5'd3, 0}});
    vecs.push_back('{"sb", 32'h00200023, 32'h1003, 32'h12345678, 32'h0, 0, 0,
                     '{1, 1, 1, 32'h1000, 4'b1000, 32'h78787878, 32'h00200023, 32'h0, 5'd0, 0}});
    vecs.push_back('{"lb", 32'h00000283, 32'h2001, 32'h0, 32'h00008000, 2, 2,
                     '{6, 1, 0, 32'h2000, 4'hF, 32'h0, 32'h00000283, 32'hFFFFFF80, 5'd5, 0}});
    vecs.push_back('{"lbu", 32'h00004283, 32'h2001, 32'h0, 32'h00008000, 2, 2,
                     '{6, 1, 0, 32'h2000, 4'hF, 32'h0, 32'h00004283, 32'h00000080, 5'd5, 0}});
    vecs.push_back('{"lh", 32'h00001283, 32'h2002, 32'h0, 32'hBEEF1234, 0, 0,
                     '{2, 1, 0, 32'h2000, 4'hF, 32'h0, 32'h00001283, 32'hFFFFBEEF, 5'd5, 0}});
    vecs.push_back('{"lhu", 32'h00005283, 32'h2002, 32'h0, 32'hBEEF1234, 1, 0,
                     '{3, 1, 0, 32'h2000, 4'hF, 32'h0, 32'h00005283, 32'h0000BEEF, 5'd5, 0}});
    vecs.push_back('{"lw", 32'h00002283, 32'h2000, 32'h0, 32'hBEEF1234, 1, 1,
                     '{4, 1, 0, 32'h2000, 4'hF, 32'h0, 32'h00002283, 32'hBEEF1234, 5'd5, 0}});
    vecs.push_back('{"lw_misaligned", 32'h00002283, 32'h3002, 32'h0, 32'h0, 0, 0,
                     '{0, 0, 0, 32'h0, 4'h0, 32'h0, 32'h0, 32'h0, 5'd0, 1}});
    vecs.push_back('{"load_f3_011", 32'h00003283, 32'h3000, 32'h0, 32'h0, 0, 0,
                     '{0, 0, 0, 32'h0, 4'h0, 32'h0, 32'h0, 32'h0, 5'd0, 1}});
    vecs.push_back('{"sh_upper", 32'h00201023, 32'h1002, 32'hAABBCCDD, 32'h0, 3, 0,
                     '{4, 1, 1, 32'h1000, 4'b1100, 32'hCCDDCCDD, 32'h00201023, 32'h0, 5'd0, 0}});
    vecs.push_back('{"sw", 32'h00202023, 32'h1004, 32'hDEADBEEF, 32'h0, 0, 0,
                     '{1, 1, 1, 32'h1004, 4'hF, 32'hDEADBEEF, 32'h00202023, 32'h0, 5'd0, 0}});
    vecs.push_back('{"sh_misaligned", 32'h00201023, 32'h1001, 32'h1, 32'h0, 0, 0,
                     '{0, 0, 0, 32'h0, 4'h0, 32'h0, 32'h0, 32'h0, 5'd0, 1}});
    vecs.push_back('{"store_f3_011", 32'h00203023, 32'h1000, 32'h1, 32'h0, 0, 0,
                     '{0, 0, 0, 32'h0, 4'h0, 32'h0, 32'h0, 32'h0, 5'd0, 1}});
    vecs.push_back('{"bubble", 32'h0, 32'h77, 32'h0, 32'h0, 0, 0,
                     '{0, 0, 0, 32'h0, 4'h0, 32'h0, 32'h0, 32'h77, 5'd0, 0}});
    vecs.push_back('{"addi", 32'h00500093, 32'h5, 32'h0, 32'h0, 0, 0,
                     '{0, 0, 0, 32'h0, 4'h0, 32'h0, 32'h00500093, 32'h5, 5'd0, 0}});

    rst_n = 0; instr_i = 0; alu_result_i = 0; rs2_i = 0;
    dmem_gnt_i = 0; dmem_rvalid_i = 0; dmem_rdata_i = 0;
    repeat (2) @(posedge clk);
    #1 check_all_zero("reset");
    @(negedge clk) rst_n = 1;

    foreach (vecs[i]) begin
      run_op(vecs[i].ins, vecs[i].alu, vecs[i].rs2, vecs[i].rdata, vecs[i].gd, vecs[i].rvd, obs);
      compare(vecs[i].name, obs, vecs[i].e);
    end

    // reset while waiting for load data
    @(negedge clk);
    instr_i = 32'h00002283; alu_result_i = 32'h2000;
    @(posedge clk); #1;
    check("rst_wait.in_req", 32'(dmem_req_o), 1);
    @(negedge clk) dmem_gnt_i = 1;
    @(posedge clk); #1;
    dmem_gnt_i = 0;
    check("rst_wait.stalled", 32'(stall_o), 1);
    rst_n = 0;
    #1 check_all_zero("rst_wait");
    @(negedge clk); instr_i = 0; alu_result_i = 0; rst_n = 1;
    run_op(32'h002081B3, 32'h99, 0, 0, 0, 0, obs);
    compare("rst_wait_after", obs, '{0, 0, 0, 32'h0, 4'h0, 32'h0, 32'h002081B3, 32'h99, 5'd3, 0});

    // reset while a store request is outstanding
    @(negedge clk);
    instr_i = 32'h00202023; alu_result_i = 32'h1008; rs2_i = 32'hCAFEF00D;
    @(posedge clk); #1;
    check("rst_req.req", 32'(dmem_req_o), 1);
    check("rst_req.addr", dmem_addr_o, 32'h1008);
    rst_n = 0;
    #1 check_all_zero("rst_req");
    @(negedge clk); instr_i = 0; alu_result_i = 0; rs2_i = 0; rst_n = 1;
    run_op(32'h00000183, 32'h4003, 0, 32'h7F00_0000, 0, 1, obs);
    compare("rst_req_after", obs, '{3, 1, 0, 32'h4000, 4'hF, 32'h0, 32'h00000183, 32'h7F, 5'd3, 0});

    // randomized operations against the reference model
    for (int k = 0; k < 200; k++) begin
      kind = $urandom_range(0, 3);
      r_ins = $urandom;
      case (kind)
        0: r_ins[6:0] = 7'h33;
        1: r_ins[6:0] = 7'h03;
        2: r_ins[6:0] = 7'h23;
        default: r_ins = ($urandom_range(0, 1) != 0) ? 32'h0 : {r_ins[31:7], 7'h13};
      endcase
      r_alu = $urandom;
      if ($urandom_range(0, 1) != 0) r_alu[1:0] = 2'b00;
      r_rs2 = $urandom; r_rdata = $urandom;
      r_gd = $urandom_range(0, 3); r_rvd = $urandom_range(0, 3);
      e = model(r_ins, r_alu, r_rs2, r_rdata, r_gd, r_rvd);
      run_op(r_ins, r_alu, r_rs2, r_rdata, r_gd, r_rvd, obs);
      compare($sformatf("rand%0d", k), obs, e);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
